// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard detection for a 5-stage MIPS-style core. Detects load-use
// and branch/jr source hazards against the EX and MEM stages. It stalls the
// front end (bubble into ID/EX, PC and IF/ID held), flushes IF/ID on a taken
// branch or jump, and freezes the whole pipe while data memory is busy. It
// also counts stall cycles.
//
// Ports
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   rs_ID, rt_ID       : source fields of the instruction in ID
//   branch_ID          : ID holds a conditional branch
//   jregister_ID       : ID holds jr
//   take_ID            : branch/jump in ID resolves taken this cycle
//   memtoreg_EX        : EX instruction is a load
//   regwrite_EX        : EX instruction writes the register file
//   writereg_EX        : EX destination register
//   memtoreg_MEM       : MEM instruction is a load
//   writereg_MEM       : MEM destination register
//   dmem_wait          : data memory not ready, freeze the whole pipe
//   stall_HD           : bubble select for the ID/EX control mux
//   pc_write           : PC register enable
//   ifid_write         : IF/ID register enable
//   ifid_flush         : clear IF/ID to a nop
//   pipe_freeze        : hold ID/EX, EX/MEM and MEM/WB
//   stall_cycles       : saturating count of cycles with stall_HD=1
//
// All outputs except stall_cycles are combinational (Mealy) decodes of the
// current state and inputs, because the stall must act in the cycle the
// hazard is seen.
// ----------------------------------------------------------------------------
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        branch_ID,
  input  logic        jregister_ID,
  input  logic        take_ID,
  input  logic        memtoreg_EX,
  input  logic        regwrite_EX,
  input  logic [4:0]  writereg_EX,
  input  logic        memtoreg_MEM,
  input  logic [4:0]  writereg_MEM,
  input  logic        dmem_wait,
  output logic        stall_HD,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        pipe_freeze,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d, state_eval;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Register 0 never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic h_lu, br_src_ex, br_src_mem;
  logic need2, need1;

  // Hazard classification.
  always_comb begin
    ex_rs      = reg_match(writereg_EX, rs_ID);
    ex_rt      = reg_match(writereg_EX, rt_ID);
    mem_rs     = reg_match(writereg_MEM, rs_ID);
    mem_rt     = reg_match(writereg_MEM, rt_ID);
    h_lu       = memtoreg_EX & (ex_rs | ex_rt);
    br_src_ex  = (branch_ID & (ex_rs | ex_rt)) | (jregister_ID & ex_rs);
    br_src_mem = (branch_ID & (mem_rs | mem_rt)) | (jregister_ID & mem_rs);
    // Branch on a load in EX needs the value out of MEM: two bubbles.
    need2      = br_src_ex & memtoreg_EX;
    need1      = h_lu
               | (br_src_ex & regwrite_EX & ~memtoreg_EX)
               | (br_src_mem & memtoreg_MEM);
  end

  // Next state and Mealy outputs; reset forces RUN evaluation.
  always_comb begin
    stall_HD    = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_eval  = rst ? RUN : state_q;
    state_d     = state_eval;

    if (dmem_wait) begin
      // Full freeze: state held so a pending HOLD resumes afterwards.
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (state_eval == HOLD) begin
      stall_HD    = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      state_d     = RUN;
    end else if (need2 || need1) begin
      stall_HD    = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      state_d     = need2 ? HOLD : RUN;
    end else begin
      ifid_flush  = take_ID;
    end
  end

  // Saturating stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_HD && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit. A behavioural model derives the
// expected outputs from the hazard rules, and the bench compares them with the
// DUT every cycle. Directed scenarios add literal expectations, followed by
// randomized traffic and a counter saturation run.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_ID, rt_ID, writereg_EX, writereg_MEM;
  logic        branch_ID, jregister_ID, take_ID;
  logic        memtoreg_EX, regwrite_EX, memtoreg_MEM, dmem_wait;
  logic        stall_HD, pc_write, ifid_write, ifid_flush, pipe_freeze;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rs_ID        (rs_ID),
    .rt_ID        (rt_ID),
    .branch_ID    (branch_ID),
    .jregister_ID (jregister_ID),
    .take_ID      (take_ID),
    .memtoreg_EX  (memtoreg_EX),
    .regwrite_EX  (regwrite_EX),
    .writereg_EX  (writereg_EX),
    .memtoreg_MEM (memtoreg_MEM),
    .writereg_MEM (writereg_MEM),
    .dmem_wait    (dmem_wait),
    .stall_HD     (stall_HD),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .pipe_freeze  (pipe_freeze),
    .stall_cycles (stall_cycles)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model state: a second bubble owed, and the stall count.
  bit m_hold = 1'b0;
  int m_cnt  = 0;

  // Outputs sampled in the most recent step, for literal checks.
  logic s_stall, s_pc, s_ifid, s_flush, s_frz;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  // Cycles of stall needed for the instruction in ID, from the hazard rules.
  function automatic int need_now();
    bit bex, bmem;
    int n;
    n    = 0;
    bex  = (branch_ID && (dep(writereg_EX, rs_ID) || dep(writereg_EX, rt_ID)))
        || (jregister_ID && dep(writereg_EX, rs_ID));
    bmem = (branch_ID && (dep(writereg_MEM, rs_ID) || dep(writereg_MEM, rt_ID)))
        || (jregister_ID && dep(writereg_MEM, rs_ID));
    if (memtoreg_EX && (dep(writereg_EX, rs_ID) || dep(writereg_EX, rt_ID))) n = 1;
    if (bex && regwrite_EX && !memtoreg_EX) n = 1;
    if (bmem && memtoreg_MEM) n = 1;
    if (bex && memtoreg_EX) n = 2;
    return n;
  endfunction

  // One clock: inputs already applied after a negedge.
  task automatic step();
    bit in_hold;
    int n;
    logic e_stall, e_pc, e_ifid, e_flush, e_frz;
    #1;
    in_hold = rst ? 1'b0 : m_hold;
    n       = need_now();
    e_stall = 0; e_pc = 0; e_ifid = 0; e_flush = 0; e_frz = 0;
    if (dmem_wait)       e_frz = 1;
    else if (in_hold)    e_stall = 1;
    else if (n >= 1)     e_stall = 1;
    else begin
      e_pc = 1; e_ifid = 1; e_flush = take_ID;
    end
    check("stall_HD",    16'(stall_HD),    16'(e_stall));
    check("pc_write",    16'(pc_write),    16'(e_pc));
    check("ifid_write",  16'(ifid_write),  16'(e_ifid));
    check("ifid_flush",  16'(ifid_flush),  16'(e_flush));
    check("pipe_freeze", 16'(pipe_freeze), 16'(e_frz));
    s_stall = stall_HD; s_pc = pc_write; s_ifid = ifid_write;
    s_flush = ifid_flush; s_frz = pipe_freeze;
    @(posedge clk);
    if (rst) begin
      m_hold = 0;
      m_cnt  = 0;
    end else if (!dmem_wait) begin
      m_hold = in_hold ? 1'b0 : (n == 2);
      if (e_stall && m_cnt < 65535) m_cnt++;
    end
    #1;
    check("stall_cycles", stall_cycles, 16'(m_cnt));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rs_ID = 0; rt_ID = 0; branch_ID = 0; jregister_ID = 0; take_ID = 0;
    memtoreg_EX = 0; regwrite_EX = 0; writereg_EX = 0;
    memtoreg_MEM = 0; writereg_MEM = 0; dmem_wait = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic branch_after_load();
    idle();
    branch_ID = 1; rs_ID = 5'd8; memtoreg_EX = 1; writereg_EX = 5'd8;
  endtask

  initial begin
    idle();
    @(negedge clk);
    rst = 1;
    step();
    check("reset_count", stall_cycles, 16'h0000);
    rst = 0;

    // Load-use on rt.
    do_reset();
    memtoreg_EX = 1; writereg_EX = 5'd5; rt_ID = 5'd5;
    step();
    check("lu_stall", 16'(s_stall), 16'd1);
    check("lu_pc",    16'(s_pc),    16'd0);
    idle(); step();
    check("lu_after", 16'(s_stall), 16'd0);
    check("lu_count", stall_cycles, 16'd1);

    // Branch after load: two stall cycles.
    do_reset();
    branch_after_load(); step();
    check("bl_stall1", 16'(s_stall), 16'd1);
    step();
    check("bl_stall2", 16'(s_stall), 16'd1);
    idle(); step();
    check("bl_run",   16'(s_stall), 16'd0);
    check("bl_count", stall_cycles, 16'd2);

    // Branch after ALU, then the register-0 case.
    do_reset();
    branch_ID = 1; rt_ID = 5'd3; regwrite_EX = 1; writereg_EX = 5'd3;
    step();
    check("ba_stall", 16'(s_stall), 16'd1);
    idle(); step();
    check("ba_run", 16'(s_stall), 16'd0);
    check("ba_count", stall_cycles, 16'd1);
    do_reset();
    branch_ID = 1; rt_ID = 5'd0; regwrite_EX = 1; writereg_EX = 5'd0;
    step();
    check("r0_stall", 16'(s_stall), 16'd0);
    check("r0_pc",    16'(s_pc),    16'd1);

    // Taken jump: flush only without a hazard.
    do_reset();
    take_ID = 1; step();
    check("tk_flush", 16'(s_flush), 16'd1);
    check("tk_pc",    16'(s_pc),    16'd1);
    memtoreg_EX = 1; writereg_EX = 5'd5; rs_ID = 5'd5;
    step();
    check("tk_hz_flush", 16'(s_flush), 16'd0);
    check("tk_hz_stall", 16'(s_stall), 16'd1);

    // Freeze for three cycles while in HOLD.
    do_reset();
    branch_after_load(); step();
    idle(); dmem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fz_freeze", 16'(s_frz),   16'd1);
      check("fz_stall",  16'(s_stall), 16'd0);
    end
    dmem_wait = 0; step();
    check("fz_hold", 16'(s_stall), 16'd1);
    step();
    check("fz_run",   16'(s_stall), 16'd0);
    check("fz_count", stall_cycles, 16'd2);

    // Reset during HOLD.
    do_reset();
    branch_after_load(); step();
    idle(); rst = 1; step();
    check("rh_stall", 16'(s_stall), 16'd0);
    check("rh_count", stall_cycles, 16'd0);
    rst = 0; step();
    check("rh_run", 16'(s_stall), 16'd0);

    // Randomized traffic on a small register range to make matches frequent.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      rs_ID        = 5'($urandom_range(0, 3));
      rt_ID        = 5'($urandom_range(0, 3));
      branch_ID    = 1'($urandom);
      jregister_ID = 1'($urandom);
      take_ID      = 1'($urandom);
      memtoreg_EX  = 1'($urandom);
      regwrite_EX  = 1'($urandom);
      writereg_EX  = 5'($urandom_range(0, 3));
      memtoreg_MEM = 1'($urandom);
      writereg_MEM = 5'($urandom_range(0, 3));
      dmem_wait    = ($urandom_range(0, 99) < 20);
      step();
    end

    // Saturation: continuous load-use stalls.
    do_reset();
    memtoreg_EX = 1; writereg_EX = 5'd5; rt_ID = 5'd5;
    for (int i = 0; i < 65534; i++) step();
    check("sat_fffe", stall_cycles, 16'hFFFE);
    for (int i = 0; i < 3; i++) step();
    check("sat_ffff", stall_cycles, 16'hFFFF);
    step();
    check("sat_hold", stall_cycles, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
